io_channel_unit: RTL and testbench
==================================

# io_channel_unit

Peripheral I/O channel block that sits directly downstream of the core's writeback stage. It consumes the core's channel-write port and answers the core's decode-stage channel-read port. Output-channel writes are latched and queued in a small FIFO. The FIFO drains to an external peripheral over a valid/ready handshake. Input channels are synchronized from asynchronous external pins, and a status channel reports queue state.

## Interface
- DEPTH, 4, output FIFO depth; power of two, 2..128
- clock  in  1  system clock
- rst_l  in  1  asynchronous, active-low reset
- IO_read_sel  in  3  channel selected by the core's decode stage
- IO_read_data  out  15  data for IO_read_sel (combinational)
- IO_write_sel  in  3  channel written by the core's writeback stage
- IO_write_data  in  15  write data
- IO_write_en  in  1  write strobe, one write per asserted cycle
- ext_in  in  45  asynchronous input pins; ch4=[14:0], ch5=[29:15], ch6=[44:30]
- out_valid  out  1  FIFO head valid
- out_ready  in  1  peripheral accepts head
- out_chan  out  2  channel number of FIFO head
- out_data  out  15  data of FIFO head
- io_full  out  1  FIFO count == DEPTH; core stall input

## Operation
- Channel map:
  - ch0–ch3: output latches.
  - ch4–ch6: synchronized inputs.
  - ch7: status/control.
- Write to ch0–ch3 (IO_write_en=1):
  - The latch for that channel always updates.
  - {sel[1:0], data} is pushed to the FIFO.
- Push with count==DEPTH and no pop in the same cycle:
  - The entry is dropped; the latch still updates.
  - Sticky ovf is set.
- Push and pop in the same cycle at full: both occur, count unchanged, ovf not set.
- Push and pop in the same cycle at empty: only the push takes effect (the pop is not valid).
- Write to ch4–ch6: ignored; no state change.
- Write to ch7: if data[0]=1, ovf clears. No FIFO push. Other bits are ignored.
- A ch7 clear and an overflow in the same cycle cannot coincide, since a single write port serves both. Clear wins trivially.
- Reads, all combinational from registered state:
  - ch0–ch3: latch value. There is no write-to-read bypass; a same-cycle read returns the old value.
  - ch4–ch6: second synchronizer flop.
  - ch7: {ovf, 6'b0, count zero-extended to 8 bits}.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - Count has $clog2(DEPTH)+1 bits.
  - A pop occurs on out_valid && out_ready at the clock edge.
- Outputs:
  - out_valid = (count != 0).
  - out_chan and out_data show the head entry when valid, and 0 when empty.
  - io_full = (count == DEPTH).
- The peripheral may hold out_ready high continuously; each cycle then drains one entry.

## Timing
- Reset (async, on rst_l low), every register cleared:
  - latches = 0, FIFO empty, pointers = 0, ovf = 0, synchronizer flops = 0.
  - Resulting outputs: out_valid = 0, out_chan = 0, out_data = 0, io_full = 0.
  - IO_read_data reads 0 on every channel.
- Reset mid-operation: queued entries are discarded and not delivered.
- Write latency:
  - Latch visible on IO_read_data the cycle after the write edge.
  - FIFO entry appears on out_valid/out_data the cycle after the push edge.
- Pop latency: the next entry (or empty) appears the cycle after the accepting edge.
- Input latency: an ext_in change is readable 2 clock edges later, via the two-flop synchronizer per bit.
- io_full:
  - Asserts the cycle after the push that fills the FIFO.
  - Deasserts the cycle after the pop that frees a slot.
  - It is registered-state derived; there is no combinational path from IO_write_en.
- ch7 count and ovf reflect state after the last edge.

## Test plan
- Reset:
  - Stimulus: assert rst_l=0 mid-stream with 3 entries queued, then release.
  - Required: out_valid=0, io_full=0, all outputs 0, IO_read_sel=7 reads 0.
- Single write:
  - Stimulus: write ch2=0o12345 with out_ready=0.
  - Required next cycle: out_valid=1, out_chan=2, out_data=0o12345, ch2 reads 0o12345, ch7 reads 1.
  - Then raise out_ready for 1 cycle. Required: out_valid=0 the following cycle.
- Fill and overflow (DEPTH=4, out_ready=0):
  - Stimulus: write ch0..ch3 with 1,2,3,4. Required: io_full=1, ch7=4.
  - Stimulus: write ch1=0o777. Required: ch1 reads 0o777, ch7 reads 0o40004, FIFO head is still ch0/1.
- Full push+pop:
  - Stimulus: at full, write ch3=5 with out_ready=1.
  - Required: count stays 4, ovf stays 0; drained order is 2,3,4,5.
- Ovf clear and wrap:
  - Stimulus: write ch7=1. Required: ch7 reads count only.
  - Stimulus: push/pop 10 entries with out_ready=1. Required: data in order, pointers wrap, no loss.
- Input sync:
  - Stimulus: change ext_in ch5 from 0 to 0o52525 at cycle t.
  - Required: ch5 reads 0 through t+1 and 0o52525 from t+2. Writes to ch5 are ignored.

Source files
------------

// File: rtl/io_channel_unit.sv
// Peripheral I/O channel block: output latches with a queued drain path,
// synchronized input channels and a status channel for the core.
module io_channel_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        rst_l,
    input  logic [2:0]  IO_read_sel,
    output logic [14:0] IO_read_data,
    input  logic [2:0]  IO_write_sel,
    input  logic [14:0] IO_write_data,
    input  logic        IO_write_en,
    input  logic [44:0] ext_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_chan,
    output logic [14:0] out_data,
    output logic        io_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [14:0]   chan_latch [4];
    logic [16:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic [44:0]   sync1;
    logic [44:0]   sync2;

    logic        push_req;
    logic        push;
    logic        pop;
    logic        ovf_set;
    logic        ovf_clr;
    logic [16:0] head;
    logic [7:0]  count_ext;

    assign push_req  = IO_write_en && !IO_write_sel[2];
    assign pop       = out_valid && out_ready;
    // At full a push only lands when the head leaves in the same cycle.
    assign push      = push_req && (!io_full || pop);
    assign ovf_set   = push_req && io_full && !pop;
    assign ovf_clr   = IO_write_en && (IO_write_sel == 3'd7) && IO_write_data[0];
    assign head      = mem[rd_ptr];
    assign count_ext = 8'(count);

    assign out_valid = (count != '0);
    assign io_full   = (count == FULL_CNT);
    assign out_chan  = out_valid ? head[16:15] : 2'd0;
    assign out_data  = out_valid ? head[14:0]  : 15'd0;

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < 4; i++) chan_latch[i] <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            sync1  <= '0;
            sync2  <= '0;
        end else begin
            sync1 <= ext_in;
            sync2 <= sync1;
            if (push_req) chan_latch[IO_write_sel[1:0]] <= IO_write_data;
            if (push) begin
                mem[wr_ptr] <= {IO_write_sel[1:0], IO_write_data};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf_clr)      ovf <= 1'b0;
            else if (ovf_set) ovf <= 1'b1;
        end
    end

    always_comb begin
        IO_read_data = '0;
        case (IO_read_sel)
            3'd0, 3'd1, 3'd2, 3'd3: IO_read_data = chan_latch[IO_read_sel[1:0]];
            3'd4:    IO_read_data = sync2[14:0];
            3'd5:    IO_read_data = sync2[29:15];
            3'd6:    IO_read_data = sync2[44:30];
            default: IO_read_data = {ovf, 6'b0, count_ext};
        endcase
    end

endmodule

// File: tb/tb_io_channel_unit.sv
// Directed bench for io_channel_unit with a queue scoreboard of FIFO entries
// and a small model of latches, overflow flag and input synchronizers.
module tb_io_channel_unit;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        rst_l;
    logic [2:0]  IO_read_sel;
    logic [14:0] IO_read_data;
    logic [2:0]  IO_write_sel;
    logic [14:0] IO_write_data;
    logic        IO_write_en;
    logic [44:0] ext_in;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_chan;
    logic [14:0] out_data;
    logic        io_full;

    io_channel_unit #(.DEPTH(DEPTH)) dut (
        .clock(clock),
        .rst_l(rst_l),
        .IO_read_sel(IO_read_sel),
        .IO_read_data(IO_read_data),
        .IO_write_sel(IO_write_sel),
        .IO_write_data(IO_write_data),
        .IO_write_en(IO_write_en),
        .ext_in(ext_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_chan(out_chan),
        .out_data(out_data),
        .io_full(io_full)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [16:0] sb[$];
    logic [14:0] m_latch [4];
    logic        m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] ch7_exp();
        return {m_ovf, 6'b0, 8'(sb.size())};
    endfunction

    // Checks registered outputs against the model, then advances one edge.
    task automatic cycle();
        logic [16:0] e;
        check("out_valid", out_valid, sb.size() != 0);
        check("io_full", io_full, sb.size() == DEPTH);
        if (sb.size() == 0) begin
            check("empty_chan", out_chan, 0);
            check("empty_data", out_data, 0);
        end
        if (out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            check("head_chan", out_chan, e[16:15]);
            check("head_data", out_data, e[14:0]);
        end
        if (IO_write_en && !IO_write_sel[2]) begin
            m_latch[IO_write_sel[1:0]] = IO_write_data;
            if (sb.size() < DEPTH) sb.push_back({IO_write_sel[1:0], IO_write_data});
            else m_ovf = 1'b1;
        end else if (IO_write_en && IO_write_sel == 3'd7 && IO_write_data[0]) begin
            m_ovf = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [14:0] data);
        IO_write_en   = 1'b1;
        IO_write_sel  = sel;
        IO_write_data = data;
        cycle();
        IO_write_en   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] sel, input logic [14:0] exp);
        IO_read_sel = sel;
        #1;
        check(tag, IO_read_data, exp);
    endtask

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < 4; i++) m_latch[i] = '0;
        m_ovf = 1'b0;
    endtask

    initial begin
        rst_l         = 1'b0;
        IO_read_sel   = '0;
        IO_write_sel  = '0;
        IO_write_data = '0;
        IO_write_en   = 1'b0;
        ext_in        = '0;
        out_ready     = 1'b0;
        model_reset();

        // Reset state
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_full", io_full, 0);
        check("rst_chan", out_chan, 0);
        check("rst_data", out_data, 0);
        for (int c = 0; c < 8; c++) rd("rst_read", 3'(c), 15'd0);
        @(negedge clock);
        rst_l = 1'b1;
        cycle();

        // Single write, then one-cycle drain
        wr(3'd2, 15'o12345);
        check("single_chan", out_chan, 2);
        check("single_data", out_data, 15'o12345);
        rd("single_ch2", 3'd2, 15'o12345);
        rd("single_ch7", 3'd7, 15'd1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("single_drained", out_valid, 0);

        // Fill, then overflow
        for (int i = 0; i < 4; i++) wr(3'(i), 15'(i + 1));
        check("fill_full", io_full, 1);
        rd("fill_ch7", 3'd7, 15'd4);
        wr(3'd1, 15'o777);
        rd("ovf_ch1", 3'd1, 15'o777);
        rd("ovf_ch7", 3'd7, 15'o40004);
        check("ovf_head_chan", out_chan, 0);
        check("ovf_head_data", out_data, 1);

        // Clear, then push and pop together at full
        wr(3'd7, 15'd1);
        rd("clr_ch7", 3'd7, ch7_exp());
        out_ready = 1'b1;
        wr(3'd3, 15'd5);
        out_ready = 1'b0;
        rd("pp_ch7", 3'd7, 15'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        out_ready = 1'b0;
        rd("pp_empty_ch7", 3'd7, 15'd0);

        // Overflow again; clear only on data[0]
        for (int i = 0; i < 5; i++) wr(3'(i % 4), 15'(100 + i));
        rd("ovf2_ch7", 3'd7, 15'o40004);
        wr(3'd7, 15'o77776);
        rd("noclr_ch7", 3'd7, 15'o40004);
        wr(3'd7, 15'd1);
        rd("clr2_ch7", 3'd7, 15'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Streaming with ready held high: pointers wrap repeatedly
        for (int i = 0; i < 10; i++) wr(3'(i % 4), 15'($urandom_range(0, 32767)));
        cycle();
        cycle();
        rd("wrap_ch7", 3'd7, 15'd0);
        rd("wrap_ch1", 3'd1, m_latch[1]);
        out_ready = 1'b0;

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) wr(3'(i), 15'(200 + i));
        rd("pre_rst_ch7", 3'd7, 15'd3);
        rst_l = 1'b0;
        model_reset();
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_full", io_full, 0);
        check("mrst_chan", out_chan, 0);
        check("mrst_data", out_data, 0);
        rd("mrst_ch7", 3'd7, 15'd0);
        rd("mrst_ch0", 3'd0, 15'd0);
        @(negedge clock);
        rst_l = 1'b1;
        cycle();
        cycle();

        // Input synchronizer latency on ch5; writes to ch5 ignored
        ext_in = {15'd0, 15'o52525, 15'd0};
        rd("sync_t0", 3'd5, 15'd0);
        cycle();
        rd("sync_t1", 3'd5, 15'd0);
        cycle();
        rd("sync_t2", 3'd5, 15'o52525);
        rd("sync_ch4", 3'd4, 15'd0);
        wr(3'd5, 15'o1111);
        rd("sync_wr_ignored", 3'd5, 15'o52525);
        rd("sync_wr_ch7", 3'd7, 15'd0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
